// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the FSM state encoding, reset PC default, instruction field positions
// and the packed control bundle handed to the next-PC selector.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned TIMEOUT_DEFAULT  = 16;

    // Jump index field of a J-type instruction.
    localparam int JUMP_IDX_MSB = 25;
    localparam int JUMP_IDX_LSB = 0;
    localparam int JUMP_IDX_W   = JUMP_IDX_MSB - JUMP_IDX_LSB + 1;

    // Region bits of PC+4 preserved by a J-type target.
    localparam int PC_REGION_MSB = 31;
    localparam int PC_REGION_LSB = 28;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Control lines that steer next-PC selection for the held instruction.
    typedef struct packed {
        logic branch;
        logic nbranch;
        logic zero;
        logic jmp;
        logic jal;
        logic jr;
    } pc_ctrl_t;

    // Sequential PC; wraps naturally modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/instruction_fetch_next_pc_select.sv
// Purpose: combinational next-PC mux for the held instruction (jr > j/jal > branch > seq).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is sampled.
//
// Ports:
//   jump_index   : instruction[25:0] of the held instruction
//   opcplus4     : PC of held instruction plus 4
//   ctrl         : branch/nbranch/zero/jmp/jal/jr bundle
//   add_result   : branch target
//   read_data_1  : register jump target
//   next_pc      : selected target with bits [1:0] forced to zero
//   misaligned   : selected target had nonzero bits [1:0]
module next_pc_select
    import instruction_fetch_pkg::*;
(
    input  logic [JUMP_IDX_W-1:0] jump_index,
    input  logic [31:0]           opcplus4,
    input  pc_ctrl_t              ctrl,
    input  logic [31:0]           add_result,
    input  logic [31:0]           read_data_1,
    output logic [31:0]           next_pc,
    output logic                  misaligned
);

    logic        take_branch;
    logic [31:0] raw_pc;

    always_comb begin
        take_branch = (ctrl.branch & ctrl.zero) | (ctrl.nbranch & ~ctrl.zero);
        raw_pc      = opcplus4;
        if (ctrl.jr) begin
            raw_pc = read_data_1;
        end else if (ctrl.jmp | ctrl.jal) begin
            raw_pc = {opcplus4[PC_REGION_MSB:PC_REGION_LSB], jump_index, 2'b00};
        end else if (take_branch) begin
            raw_pc = add_result;
        end
    end

    // Word alignment is enforced here; the flag lets the top report it.
    assign misaligned = |raw_pc[1:0];
    assign next_pc    = {raw_pc[31:2], 2'b00};

endmodule

// File: rtl/instruction_fetch.sv
// Purpose: instruction fetch FSM (IDLE/FETCH/HOLD/ERROR) with PC, timeout counter and held instruction.
// Latency: word captured on the imem_valid cycle, inst_valid the next cycle; advance -> FETCH next cycle.
// Backpressure: instruction held in HOLD until advance; FETCH times out into a sticky ERROR.
//
// Ports:
//   clk, rst                : single clock, synchronous active-high reset
//   imem_req/imem_addr      : read request, address = PC, asserted only in FETCH
//   imem_rdata/imem_valid   : returned word, honoured only in FETCH
//   instruction/opcplus4    : held word and its PC+4, valid while inst_valid
//   advance                 : downstream consumed the held instruction
//   branch..jr, add_result,
//   read_data_1             : next-PC controls, sampled on HOLD && advance only
//   misaligned              : one-cycle pulse when the chosen target was not word aligned
//   fetch_timeout           : sticky, set while in ERROR
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instruction,
    output logic [31:0] opcplus4,
    output logic        inst_valid,
    input  logic        advance,
    input  logic        branch,
    input  logic        nbranch,
    input  logic        zero,
    input  logic        jmp,
    input  logic        jal,
    input  logic        jr,
    input  logic [31:0] add_result,
    input  logic [31:0] read_data_1,
    output logic        misaligned,
    output logic        fetch_timeout
);

    // Counter must be able to hold TIMEOUT itself.
    localparam int             CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [31:0]      pc;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;

    logic             load_inst;
    logic             load_pc;
    logic             cnt_clr;
    logic             cnt_step;

    pc_ctrl_t         ctrl;
    logic [31:0]      sel_next_pc;
    logic             sel_misaligned;

    always_comb begin
        ctrl         = '0;
        ctrl.branch  = branch;
        ctrl.nbranch = nbranch;
        ctrl.zero    = zero;
        ctrl.jmp     = jmp;
        ctrl.jal     = jal;
        ctrl.jr      = jr;
    end

    next_pc_select u_next_pc_select (
        .jump_index  (instruction[JUMP_IDX_MSB:JUMP_IDX_LSB]),
        .opcplus4    (opcplus4),
        .ctrl        (ctrl),
        .add_result  (add_result),
        .read_data_1 (read_data_1),
        .next_pc     (sel_next_pc),
        .misaligned  (sel_misaligned)
    );

    assign wait_cnt_inc = wait_cnt + CNT_ONE;

    // Next-state and control strobes.
    always_comb begin
        state_nxt = state;
        load_inst = 1'b0;
        load_pc   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
                cnt_clr   = 1'b1;
            end
            ST_FETCH: begin
                // A response arriving on the final allowed cycle still wins.
                if (imem_valid) begin
                    state_nxt = ST_HOLD;
                    load_inst = 1'b1;
                end else begin
                    cnt_step = 1'b1;
                    if (wait_cnt_inc == TIMEOUT_CNT) begin
                        state_nxt = ST_ERROR;
                    end
                end
            end
            ST_HOLD: begin
                if (advance) begin
                    state_nxt = ST_FETCH;
                    load_pc   = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        imem_req      = (state == ST_FETCH);
        inst_valid    = (state == ST_HOLD);
        fetch_timeout = (state == ST_ERROR);
        imem_addr     = pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            opcplus4    <= '0;
            wait_cnt    <= '0;
            misaligned  <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Pulse lasts exactly the first FETCH cycle after the redirect.
            misaligned <= load_pc & sel_misaligned;

            if (load_pc) begin
                pc <= sel_next_pc;
            end

            if (load_inst) begin
                instruction <= imem_rdata;
                opcplus4    <= pc_plus4(pc);
            end

            if (cnt_clr) begin
                wait_cnt <= '0;
            end else if (cnt_step) begin
                wait_cnt <= wait_cnt_inc;
            end
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address loaded into PC on reset.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum FETCH-state cycles allowed without imem_valid.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  32  byte address of requested word, equal to PC.
REQ-007 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-008 SHALL have port imem_valid  input  1  imem_rdata valid this cycle.
REQ-009 SHALL have port instruction  output  32  held instruction word for the decoder.
REQ-010 SHALL have port opcplus4  output  32  PC of held instruction plus 4, for jal link.
REQ-011 SHALL have port inst_valid  output  1  instruction/opcplus4 valid.
REQ-012 SHALL have port advance  input  1  downstream has consumed the held instruction.
REQ-013 SHALL have ports branch, nbranch, zero, jmp, jal, jr  input  1 each  control for the held instruction.
REQ-014 SHALL have ports add_result, read_data_1  input  32 each  branch target and jr target.
REQ-015 SHALL have ports misaligned  output  1  one-cycle pulse; fetch_timeout  output  1  sticky error.

Function
REQ-016 SHALL implement states IDLE, FETCH, HOLD, ERROR.
REQ-017 IDLE SHALL go to FETCH unconditionally next cycle.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC; otherwise imem_req SHALL be 0.
REQ-019 In FETCH with imem_valid=1, instruction SHALL capture imem_rdata, opcplus4 SHALL capture PC+4, and state SHALL go to HOLD.
REQ-020 imem_valid SHALL be ignored outside FETCH.
REQ-021 inst_valid SHALL be 1 exactly in HOLD; instruction/opcplus4 SHALL stay stable throughout HOLD.
REQ-022 In HOLD with advance=1, PC SHALL load next-PC and state SHALL go to FETCH; advance=0 holds.
REQ-023 Next-PC priority SHALL be: jr -> read_data_1; else jmp or jal -> {opcplus4[31:28], instruction[25:0], 2'b00}; else (branch & zero) or (nbranch & ~zero) -> add_result; else opcplus4.
REQ-024 Selected next-PC with bits [1:0] nonzero SHALL load with bits [1:0] cleared and pulse misaligned for one cycle.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-026 FETCH timeout counter SHALL clear on FETCH entry and increment each FETCH cycle without imem_valid; reaching TIMEOUT SHALL move to ERROR.
REQ-027 imem_valid in the same cycle the counter reaches TIMEOUT SHALL win: capture and go to HOLD.
REQ-028 ERROR SHALL hold fetch_timeout=1, imem_req=0, inst_valid=0 until rst.
REQ-029 Control inputs SHALL be sampled only in the HOLD cycle with advance=1.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, PC=RESET_PC, instruction=0, opcplus4=0, counter=0, inst_valid=0, imem_req=0, misaligned=0, fetch_timeout=0.
REQ-031 rst mid-FETCH SHALL discard the outstanding request; a late imem_valid after reset SHALL be ignored until the next FETCH.
REQ-032 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-033 Shared package SHALL hold state encoding, RESET_PC default, and instruction field positions (jump index [25:0]).
REQ-034 Next-PC selection SHALL be one combinational sub-module named next_pc_select; FSM, PC, and counter stay in instruction_fetch.

Verification
REQ-035 Reset then imem_valid on 2nd FETCH cycle with 32'h2008_0005 -> imem_addr=0, HOLD, instruction=32'h2008_0005, opcplus4=4, inst_valid=1.
REQ-036 HOLD with opcplus4=8, branch=1, zero=1, add_result=32'h20, advance=1 -> next imem_addr=32'h20; with zero=0 -> 8.
REQ-037 HOLD with jr=1, jmp=1, read_data_1=32'h46 -> PC=32'h44, misaligned pulses one cycle.
REQ-038 instruction=32'h0C00_0010 (jal), opcplus4=32'h0040_0004 -> next imem_addr=32'h0000_0040.
REQ-039 imem_valid withheld 16 FETCH cycles -> ERROR, fetch_timeout=1, imem_req=0; valid on exactly the 16th cycle -> HOLD instead.
REQ-040 rst asserted mid-FETCH, imem_valid one cycle after rst release -> ignored (state IDLE), fresh fetch at RESET_PC.
